// File: rtl/io_port_bridge.sv
// Bridges a 64-bit host stream to a strobe-driven CPU port through two
// independent circular FIFOs, with sticky underflow/overflow flags.
module io_port_bridge #(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          host_in_valid,
   input  logic [63:0]   host_in_data,
   output logic          host_in_ready,
   input  logic          in_signal,
   output logic [63:0]   in_data,
   input  logic          out_signal,
   input  logic [63:0]   out_data,
   output logic          host_out_valid,
   output logic [63:0]   host_out_data,
   input  logic          host_out_ready,
   output logic [CW-1:0] in_count,
   output logic [CW-1:0] out_count,
   input  logic          clear_err,
   output logic          in_underflow,
   output logic          out_overflow,
   output logic          error
);

   localparam int AW = $clog2(DEPTH);

   // Handshake: a host word moves on a posedge where valid and ready are both
   // high; ready/valid never depend combinationally on the partner's signal.
   logic [63:0]   in_mem  [DEPTH];
   logic [63:0]   out_mem [DEPTH];
   logic [AW-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
   logic          in_sig_q, out_sig_q;

   logic in_push, in_rd_evt, in_pop, in_unf_set;
   logic out_wr_evt, out_pop, out_store, out_ovf_set, out_full;

   always_comb begin
      host_in_ready  = (in_count != CW'(DEPTH));
      host_out_valid = (out_count != '0);
      out_full       = (out_count == CW'(DEPTH));
      in_data        = (in_count != '0) ? in_mem[in_rd_ptr] : 64'h0;
      host_out_data  = host_out_valid ? out_mem[out_rd_ptr] : 64'h0;
      error          = in_underflow | out_overflow;

      in_push     = host_in_valid & host_in_ready;
      in_rd_evt   = in_signal & ~in_sig_q;
      in_pop      = in_rd_evt & (in_count != '0);
      in_unf_set  = in_rd_evt & (in_count == '0);

      out_wr_evt  = out_signal & ~out_sig_q;
      out_pop     = host_out_valid & host_out_ready;
      // A full output FIFO still takes a write when the host frees a slot
      // on the same edge.
      out_store   = out_wr_evt & (~out_full | out_pop);
      out_ovf_set = out_wr_evt & out_full & ~out_pop;
   end

   // Edge registers track the strobes even during reset, so a strobe held
   // across reset release is not seen as a new event.
   always_ff @(posedge clk) begin
      in_sig_q  <= in_signal;
      out_sig_q <= out_signal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_wr_ptr    <= '0;
         in_rd_ptr    <= '0;
         out_wr_ptr   <= '0;
         out_rd_ptr   <= '0;
         in_count     <= '0;
         out_count    <= '0;
         in_underflow <= 1'b0;
         out_overflow <= 1'b0;
      end else begin
         if (in_push)   in_wr_ptr  <= in_wr_ptr + 1'b1;
         if (in_pop)    in_rd_ptr  <= in_rd_ptr + 1'b1;
         if (out_store) out_wr_ptr <= out_wr_ptr + 1'b1;
         if (out_pop)   out_rd_ptr <= out_rd_ptr + 1'b1;
         in_count  <= in_count + CW'(in_push) - CW'(in_pop);
         out_count <= out_count + CW'(out_store) - CW'(out_pop);
         if (in_unf_set)     in_underflow <= 1'b1;
         else if (clear_err) in_underflow <= 1'b0;
         if (out_ovf_set)    out_overflow <= 1'b1;
         else if (clear_err) out_overflow <= 1'b0;
      end
   end

   // Storage has no reset; only the pointers and counts define its contents.
   always_ff @(posedge clk) begin
      if (!reset && in_push)   in_mem[in_wr_ptr]   <= host_in_data;
      if (!reset && out_store) out_mem[out_wr_ptr] <= out_data;
   end

endmodule
